// File: rtl/alu_result_select.sv
// One-hot AND-OR result select feeding a 2-entry elastic buffer with
// valid/ready on both sides and sticky/saturating malformed-select tracking.
module alu_result_select #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       sel,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          data_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err,
  output logic [7:0]                err_count,
  input  logic                      err_clear
);

  typedef enum logic [1:0] {
    EMPTY,
    HALF,
    FULL
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] tail;
  logic [WIDTH-1:0] result;
  logic [4:0]       ones;
  logic             bad;
  logic             accept;
  logic             emit;

  // Legacy AND-OR semantics: zero-hot gives 0, multi-hot ORs the channels.
  always_comb begin
    result = '0;
    ones   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (sel[i]) result = result | data_in[i*WIDTH +: WIDTH];
      ones = ones + 5'(sel[i]);
    end
    bad = (ones != 5'd1);
  end

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  // data_out is the head entry itself, so out_valid/in_ready/data_out are all flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      data_out  <= '0;
      tail      <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            data_out  <= result;
            state     <= HALF;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        HALF: begin
          if (accept && emit) begin
            data_out <= result;
          end else if (accept) begin
            tail     <= result;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (emit) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (emit) begin
            data_out <= tail;
            state    <= HALF;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  // A bad accept takes priority over err_clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err   <= 1'b0;
      err_count <= '0;
    end else if (accept && bad) begin
      sel_err   <= 1'b1;
      if (err_clear)
        err_count <= 8'd1;
      else if (err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end else if (err_clear) begin
      sel_err   <= 1'b0;
      err_count <= '0;
    end
  end

endmodule

// File: tb/tb_alu_result_select.sv
// Scoreboard bench for alu_result_select: default 8x4 instance plus a 16x8 instance.
module tb_alu_result_select;

  logic         clk;
  logic         rst;

  logic [3:0]   a_sel;
  logic [31:0]  a_data;
  logic         a_valid, a_irdy, a_ovalid, a_ordy, a_err, a_clr;
  logic [7:0]   a_dout, a_cnt;

  logic [7:0]   b_sel;
  logic [127:0] b_data;
  logic         b_valid, b_irdy, b_ovalid, b_ordy, b_err, b_clr;
  logic [15:0]  b_dout;
  logic [7:0]   b_cnt;

  logic [15:0]  qa[$];
  logic [15:0]  qb[$];
  logic         a_eflag, b_eflag;
  int           a_ecnt, b_ecnt;

  int errors = 0;
  int checks = 0;

  alu_result_select #(.WIDTH(8), .CHANNELS(4)) dut_a (
    .clk(clk), .rst(rst), .sel(a_sel), .data_in(a_data), .in_valid(a_valid),
    .in_ready(a_irdy), .data_out(a_dout), .out_valid(a_ovalid), .out_ready(a_ordy),
    .sel_err(a_err), .err_count(a_cnt), .err_clear(a_clr)
  );

  alu_result_select #(.WIDTH(16), .CHANNELS(8)) dut_b (
    .clk(clk), .rst(rst), .sel(b_sel), .data_in(b_data), .in_valid(b_valid),
    .in_ready(b_irdy), .data_out(b_dout), .out_valid(b_ovalid), .out_ready(b_ordy),
    .sel_err(b_err), .err_count(b_cnt), .err_clear(b_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] andor(input logic [7:0] s, input logic [127:0] d, input int w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (s[i])
        for (int b = 0; b < w; b++)
          r[b] = r[b] | d[i*w + b];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("a_in_ready", 32'(a_irdy), 32'(qa.size() < 2));
    chk("a_out_valid", 32'(a_ovalid), 32'(qa.size() > 0));
    if (qa.size() > 0) chk("a_data_out", 32'(a_dout), 32'(qa[0][7:0]));
    chk("a_sel_err", 32'(a_err), 32'(a_eflag));
    chk("a_err_count", 32'(a_cnt), 32'(a_ecnt));
    chk("b_in_ready", 32'(b_irdy), 32'(qb.size() < 2));
    chk("b_out_valid", 32'(b_ovalid), 32'(qb.size() > 0));
    if (qb.size() > 0) chk("b_data_out", 32'(b_dout), 32'(qb[0]));
    chk("b_sel_err", 32'(b_err), 32'(b_eflag));
    chk("b_err_count", 32'(b_cnt), 32'(b_ecnt));
  endtask

  function automatic int next_cnt(input int cnt, input logic clr);
    if (clr) return 1;
    return (cnt == 255) ? 255 : cnt + 1;
  endfunction

  // One clock: predict handshakes from the model, advance the edge, update, compare.
  task automatic cyc();
    logic acc_a, emit_a, bad_a, clr_a, acc_b, emit_b, bad_b, clr_b;
    logic [15:0] res_a, res_b;
    acc_a  = a_valid && (qa.size() < 2);
    emit_a = (qa.size() > 0) && a_ordy;
    res_a  = andor({4'b0, a_sel}, {96'b0, a_data}, 8);
    bad_a  = ($countones(a_sel) != 1);
    clr_a  = a_clr;
    acc_b  = b_valid && (qb.size() < 2);
    emit_b = (qb.size() > 0) && b_ordy;
    res_b  = andor(b_sel, b_data, 16);
    bad_b  = ($countones(b_sel) != 1);
    clr_b  = b_clr;
    @(posedge clk);
    #1;
    if (emit_a) void'(qa.pop_front());
    if (acc_a) qa.push_back(res_a);
    if (acc_a && bad_a) begin a_eflag = 1'b1; a_ecnt = next_cnt(a_ecnt, clr_a); end
    else if (clr_a) begin a_eflag = 1'b0; a_ecnt = 0; end
    if (emit_b) void'(qb.pop_front());
    if (acc_b) qb.push_back(res_b);
    if (acc_b && bad_b) begin b_eflag = 1'b1; b_ecnt = next_cnt(b_ecnt, clr_b); end
    else if (clr_b) begin b_eflag = 1'b0; b_ecnt = 0; end
    check_outputs();
  endtask

  task automatic model_reset();
    qa.delete(); qb.delete();
    a_eflag = 1'b0; a_ecnt = 0;
    b_eflag = 1'b0; b_ecnt = 0;
  endtask

  initial begin
    rst = 1'b1;
    a_sel = '0; a_data = '0; a_valid = 1'b0; a_ordy = 1'b0; a_clr = 1'b0;
    b_sel = '0; b_data = '0; b_valid = 1'b0; b_ordy = 1'b0; b_clr = 1'b0;
    model_reset();
    #12;
    check_outputs();
    chk("reset_a_dout", 32'(a_dout), 32'h0);
    rst = 1'b0;
    cyc();

    // Streaming at full rate
    a_ordy = 1'b1;
    a_data = 32'h44332211;
    for (int i = 0; i < 4; i++) begin
      a_sel = 4'(1 << i); a_valid = 1'b1;
      cyc();
      chk("stream_data", 32'(a_dout), 32'(8'h11 * (i + 1)));
    end
    a_valid = 1'b0;
    cyc(); cyc();

    // Back-pressure: third attempt held until space frees
    a_ordy = 1'b0; a_valid = 1'b1; a_data = 32'hD4C3B2A1;
    a_sel = 4'b0001; cyc();
    a_sel = 4'b0010; cyc();
    chk("bp_full_in_ready", 32'(a_irdy), 32'h0);
    a_sel = 4'b0100; cyc();
    a_ordy = 1'b1; cyc();
    chk("bp_first_pop_data", 32'(a_dout), 32'hB2);
    cyc();
    a_valid = 1'b0;
    chk("bp_third_data", 32'(a_dout), 32'hC3);
    cyc(); cyc();

    // Malformed selects
    a_valid = 1'b1; a_sel = 4'b0000; a_data = 32'h5A5A5A5A;
    cyc();
    chk("malf_zero_data", 32'(a_dout), 32'h00);
    chk("malf_zero_cnt", 32'(a_cnt), 32'd1);
    a_sel = 4'b0011; a_data = 32'h0000F00F;
    cyc();
    a_valid = 1'b0;
    chk("malf_multi_data", 32'(a_dout), 32'hFF);
    chk("malf_multi_cnt", 32'(a_cnt), 32'd2);
    cyc();

    // Saturation and clear
    a_valid = 1'b1; a_sel = 4'b0000;
    for (int i = 0; i < 300; i++) cyc();
    chk("sat_cnt", 32'(a_cnt), 32'd255);
    a_valid = 1'b0; a_clr = 1'b1;
    cyc();
    chk("clear_err", 32'(a_err), 32'h0);
    chk("clear_cnt", 32'(a_cnt), 32'h0);
    a_valid = 1'b1; a_sel = 4'b0101; a_data = 32'h00010001;
    cyc();
    a_valid = 1'b0; a_clr = 1'b0;
    chk("clear_vs_set_err", 32'(a_err), 32'h1);
    chk("clear_vs_set_cnt", 32'(a_cnt), 32'h1);
    cyc(); cyc();

    // Asynchronous reset with two entries buffered
    a_ordy = 1'b0; a_valid = 1'b1; a_data = 32'h77665544;
    a_sel = 4'b0001; cyc();
    a_sel = 4'b1000; cyc();
    a_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("rst_mid_dout", 32'(a_dout), 32'h0);
    #2 rst = 1'b0;
    a_ordy = 1'b1;
    cyc();

    // Wider instance: random one-hot selects, random back-pressure
    for (int i = 0; i < 200; i++) begin
      b_valid = 1'($urandom_range(0, 1));
      b_sel   = 8'(1 << $urandom_range(0, 7));
      b_data  = {$urandom, $urandom, $urandom, $urandom};
      b_ordy  = 1'($urandom_range(0, 1));
      cyc();
    end
    b_valid = 1'b0; b_ordy = 1'b1;
    cyc(); cyc(); cyc();
    chk("b_drained_valid", 32'(b_ovalid), 32'h0);
    chk("b_no_sel_err", 32'(b_err), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_select.md
# alu_result_select

Parametrised, registered successor to the 4-input one-hot ALU result multiplexer. Selects one of CHANNELS operand-unit results of WIDTH bits with a one-hot select and registers the result into a 2-entry elastic buffer with valid/ready handshakes on both sides. It sits between the ALU functional units and the writeback stage. It adds back-pressure, full throughput and malformed-select detection, none of which the combinational mux had.

## Interface
Parameters:
- WIDTH, 8, data width of each channel and of the output
- CHANNELS, 4, number of input channels (2..16); sel is one bit per channel

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- sel  input  CHANNELS  one-hot channel select; bit i picks channel i
- data_in  input  CHANNELS*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH]
- in_valid  input  1  sel/data_in valid
- in_ready  output  1  block can accept; registered
- data_out  output  WIDTH  head entry of buffer
- out_valid  output  1  data_out valid
- out_ready  input  1  downstream accepts data_out
- sel_err  output  1  sticky: an accepted transfer had a non-one-hot sel
- err_count  output  8  saturating count of accepted non-one-hot transfers
- err_clear  input  1  synchronous clear of sel_err and err_count

## Operation
- Select function is AND-OR, matching legacy semantics: result = OR over i of (sel[i] ? channel i : 0).
  - Zero-hot sel yields 0.
  - Multi-hot sel yields the bitwise OR of the selected channels.
- Accept: in_valid && in_ready at a rising edge. Emit: out_valid && out_ready at a rising edge.
- Buffer has two entries (head, tail) and a state machine:
  - EMPTY: out_valid=0, in_ready=1. Accept -> HALF, with head = result.
  - HALF: out_valid=1, in_ready=1.
    - Accept and emit -> HALF, head = new result.
    - Accept only -> FULL, tail = result.
    - Emit only -> EMPTY.
  - FULL: out_valid=1, in_ready=0; no accept possible. Emit -> HALF, head = tail.
- Data ordering is strict FIFO; no entry is dropped or duplicated.
- Error check on every accepted transfer: bad = popcount(sel) != 1.
  - bad sets sel_err.
  - bad increments err_count, saturating at 255.
  - The transfer is still forwarded with the AND-OR result.
- err_clear clears sel_err and err_count to 0. If a bad accept occurs in the same cycle, the set wins: sel_err=1, err_count=1.
- Inputs are ignored when in_valid=0. sel and data_in are ignored when no accept occurs.

## Timing
- Reset (async, immediate on rst rise): state=EMPTY, out_valid=0, in_ready=1, data_out=0, sel_err=0, err_count=0; both entries cleared to 0.
- Reset asserted mid-transfer discards buffered entries. The first accept is possible at the first rising edge after rst falls.
- Latency: data accepted at edge N appears on data_out with out_valid=1 after edge N, provided the buffer was EMPTY or was HALF with a simultaneous emit.
- Throughput: one transfer per cycle with out_ready held at 1.
- in_ready drops the cycle after the buffer goes FULL and is never combinationally dependent on out_ready.
- data_out and out_valid are register outputs; there is no combinational path from input to output.
- sel_err and err_count update at the edge of the accepted transfer and are visible the following cycle.

## Test plan
- Reset check: assert rst mid-cycle -> outputs immediately show out_valid=0, in_ready=1, data_out=0, sel_err=0, err_count=0.
- Streaming: WIDTH=8, CHANNELS=4, out_ready=1, channels 0x11/0x22/0x33/0x44, sel cycling 0001,0010,0100,1000 -> data_out 0x11,0x22,0x33,0x44 on consecutive cycles at 1-cycle latency, in_ready stays 1.
- Back-pressure: out_ready=0, three accept attempts -> two accepted, in_ready=0 after the second. Raise out_ready -> data emitted in order, then the third is accepted, with no loss or duplication.
- Malformed select: sel=0000 -> data_out=0x00, sel_err=1, err_count=1. sel=0011 with 0x0F/0xF0 -> data_out=0xFF, err_count=2.
- Error saturation and clear: 300 bad accepts -> err_count=255. err_clear alone -> sel_err=0, err_count=0. err_clear with a bad accept in the same cycle -> sel_err=1, err_count=1.
- Parametrisation: WIDTH=16, CHANNELS=8 with a random one-hot select and random out_ready -> the scoreboard matches the selected channel in order, with sel_err=0 throughout.
